// File: rtl/fb_clk_switch_ctrl_pkg.sv
// Shared types for the clock-switch controller: FSM states, error codes, timer width.
package fb_clk_switch_ctrl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_SRC_OFF  = 2'd2,
        ERR_SRC_LOST = 2'd3
    } err_code_e;

    localparam int TIMER_W = 8;

endpackage

// File: rtl/fb_settle_timer.sv
// Loadable down-counter; expire_o is high while running with the count at zero.
module fb_settle_timer
    import fb_clk_switch_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               run_i,
    output logic               expire_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/fb_clk_switch_ctrl.sv
// Request/handshake controller driving the select of the glitch-free clock switch.
// Optional autonomous fallback to DEFAULT_SEL: define FB_CLK_SWITCH_CTRL_FALLBACK_EN.
module fb_clk_switch_ctrl
    import fb_clk_switch_ctrl_pkg::*;
#(
    parameter int N           = 4,
    parameter int M           = 2,
    parameter int DEFAULT_SEL = 0,
    parameter int SETTLE_CYC  = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic [M-1:0] req_sel,
    output logic         req_ready,
    input  logic [N-1:0] src_en,
    output logic [M-1:0] select,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_code
);

`ifdef FB_CLK_SWITCH_CTRL_FALLBACK_EN
    localparam bit FB_EN = 1'b1;
`else
    localparam bit FB_EN = 1'b0;
`endif

    state_e         state_q, state_d;
    logic [M-1:0]   select_q, select_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    err_code_e      code_q, code_d;
    logic           fb_q, fb_d;
    logic           load;
    logic           expire;
    logic [2**M-1:0] src_ext;
    logic           cur_on;
    logic           fb_trig;

    // Widen src_en so any M-bit index is safe; unpopulated sources read as off.
    always_comb begin
        src_ext        = '0;
        src_ext[N-1:0] = src_en;
    end

    assign cur_on  = src_ext[select_q];
    assign fb_trig = FB_EN && (state_q == IDLE) && !cur_on
                     && (select_q != M'(DEFAULT_SEL)) && src_ext[DEFAULT_SEL];

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
        fb_d     = fb_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fb_trig) begin
                    state_d  = SETTLE;
                    select_d = M'(DEFAULT_SEL);
                    fb_d     = 1'b1;
                    load     = 1'b1;
                end else if (req_valid) begin
                    if (int'(req_sel) >= N) begin
                        err_d  = 1'b1;
                        code_d = ERR_RANGE;
                    end else if (!src_ext[req_sel]) begin
                        err_d  = 1'b1;
                        code_d = ERR_SRC_OFF;
                    end else if (req_sel == select_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = SETTLE;
                        select_d = req_sel;
                        fb_d     = 1'b0;
                        load     = 1'b1;
                    end
                end
            end
            SETTLE: begin
                // Loss of the new source wins over a coinciding timer expiry.
                if (!cur_on) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_SRC_LOST;
                end else if (expire) begin
                    state_d = IDLE;
                    if (fb_q) begin
                        err_d  = 1'b1;
                        code_d = ERR_SRC_LOST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            select_q <= M'(DEFAULT_SEL);
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            fb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            fb_q     <= fb_d;
        end
    end

    fb_settle_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .load_val_i (TIMER_W'(SETTLE_CYC - 1)),
        .run_i      (state_q == SETTLE),
        .expire_o   (expire)
    );

    assign req_ready = (state_q == IDLE) && !fb_trig;
    assign select    = select_q;
    assign busy      = (state_q == SETTLE);
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_fb_clk_switch_ctrl.sv
// Bench for fb_clk_switch_ctrl: a 4-source and a 3-source instance checked every cycle against a behavioural model.
module tb_fb_clk_switch_ctrl;

    localparam int SETTLE = 8;

`ifdef FB_CLK_SWITCH_CTRL_FALLBACK_EN
    localparam bit FB_EN = 1'b1;
`else
    localparam bit FB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid4 = 1'b0, valid3 = 1'b0;
    logic [1:0] sel_in4 = '0, sel_in3 = '0;
    logic [3:0] src4 = 4'b1111;
    logic [2:0] src3 = 3'b111;
    logic       rdy4, busy4, done4, err4, rdy3, busy3, done3, err3;
    logic [1:0] sel4, code4, sel3, code3;

    int  total = 0;
    int  bad = 0;
    bit  chk_en = 1'b0;

    // Model state: current select, remaining busy cycles (0 = idle), fallback flag, pulses.
    int  m_sel[2]  = '{0, 0};
    int  m_rem[2]  = '{0, 0};
    bit  m_fb[2]   = '{0, 0};
    bit  m_done[2] = '{0, 0};
    bit  m_err[2]  = '{0, 0};
    int  m_code[2] = '{0, 0};
    int  n_src[2]  = '{4, 3};

    always #5 clk = ~clk;

    fb_clk_switch_ctrl #(.N(4), .M(2), .DEFAULT_SEL(0), .SETTLE_CYC(SETTLE)) u_dut4 (
        .clk(clk), .reset(rst), .req_valid(valid4), .req_sel(sel_in4), .req_ready(rdy4),
        .src_en(src4), .select(sel4), .busy(busy4), .done(done4), .err(err4), .err_code(code4));

    fb_clk_switch_ctrl #(.N(3), .M(2), .DEFAULT_SEL(0), .SETTLE_CYC(SETTLE)) u_dut3 (
        .clk(clk), .reset(rst), .req_valid(valid3), .req_sel(sel_in3), .req_ready(rdy3),
        .src_en(src3), .select(sel3), .busy(busy3), .done(done3), .err(err3), .err_code(code3));

    task automatic cmp(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] en_of(int i);
        return (i == 0) ? src4 : {1'b0, src3};
    endfunction

    function automatic bit fb_now(logic [3:0] en, int sel);
        return FB_EN && !en[sel] && (sel != 0) && en[0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_sel[i] = 0; m_rem[i] = 0; m_fb[i] = 0;
                m_done[i] = 0; m_err[i] = 0; m_code[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [3:0] en;
                bit         v;
                int         s;
                en = en_of(i);
                v  = (i == 0) ? valid4 : valid3;
                s  = (i == 0) ? int'(sel_in4) : int'(sel_in3);
                m_done[i] = 0;
                m_err[i]  = 0;
                if (m_rem[i] != 0) begin
                    if (!en[m_sel[i]]) begin
                        m_rem[i] = 0; m_err[i] = 1; m_code[i] = 3;
                    end else if (m_rem[i] == 1) begin
                        m_rem[i] = 0;
                        if (m_fb[i]) begin m_err[i] = 1; m_code[i] = 3; end
                        else m_done[i] = 1;
                    end else begin
                        m_rem[i]--;
                    end
                end else if (fb_now(en, m_sel[i])) begin
                    m_sel[i] = 0; m_rem[i] = SETTLE; m_fb[i] = 1;
                end else if (v) begin
                    if (s >= n_src[i]) begin m_err[i] = 1; m_code[i] = 1; end
                    else if (!en[s]) begin m_err[i] = 1; m_code[i] = 2; end
                    else if (s == m_sel[i]) m_done[i] = 1;
                    else begin m_sel[i] = s; m_rem[i] = SETTLE; m_fb[i] = 0; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit exp_rdy;
                exp_rdy = (m_rem[i] == 0) && !fb_now(en_of(i), m_sel[i]);
                cmp($sformatf("u%0d.select", i), (i == 0) ? int'(sel4) : int'(sel3), m_sel[i]);
                cmp($sformatf("u%0d.req_ready", i), (i == 0) ? int'(rdy4) : int'(rdy3), int'(exp_rdy));
                cmp($sformatf("u%0d.busy", i), (i == 0) ? int'(busy4) : int'(busy3), int'(m_rem[i] != 0));
                cmp($sformatf("u%0d.done", i), (i == 0) ? int'(done4) : int'(done3), int'(m_done[i]));
                cmp($sformatf("u%0d.err", i), (i == 0) ? int'(err4) : int'(err3), int'(m_err[i]));
                cmp($sformatf("u%0d.err_code", i), (i == 0) ? int'(code4) : int'(code3), m_code[i]);
            end
        end
    end

    task automatic req4(int s);
        @(posedge clk); #2;
        valid4 = 1'b1; sel_in4 = 2'(s);
        @(posedge clk); #2;
        valid4 = 1'b0;
    endtask

    task automatic req3(int s);
        @(posedge clk); #2;
        valid3 = 1'b1; sel_in3 = 2'(s);
        @(posedge clk); #2;
        valid3 = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int done_k;

        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        cmp("reset select", sel4, 0);
        cmp("reset ready", rdy4, 1);
        cmp("reset busy", busy4, 0);
        cmp("reset err_code", code4, 0);

        // Target source not running.
        src4 = 4'b1011;
        req4(2);
        @(negedge clk);
        cmp("off err", err4, 1);
        cmp("off code", code4, 2);
        cmp("off select", sel4, 0);
        cmp("off busy", busy4, 0);
        src4 = 4'b1111;

        // Out-of-range on the 3-source instance, then a no-op request.
        req3(3);
        @(negedge clk);
        cmp("range err", err3, 1);
        cmp("range code", code3, 1);
        req3(0);
        @(negedge clk);
        cmp("same done", done3, 1);
        cmp("same busy", busy3, 0);

        // Normal switch to 2: 8 busy cycles, done at T+9.
        req4(2);
        busy_cnt = 0; done_k = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (busy4) busy_cnt++;
            if (done4 && done_k == 0) done_k = k;
            if (k == 1) cmp("switch select", sel4, 2);
        end
        cmp("switch busy cycles", busy_cnt, 8);
        cmp("switch done cycle", done_k, 9);
        cmp("switch ready at done", rdy4, 1);

        // Source lost during settle.
        req4(1);
        repeat (3) @(posedge clk);
        #2 src4 = 4'b1101;
        @(posedge clk);
        #2 src4 = 4'b1111;
        @(negedge clk);
        cmp("lost err", err4, 1);
        cmp("lost code", code4, 3);
        cmp("lost select", sel4, 1);
        cmp("lost ready", rdy4, 1);

        // Requests held during settle are ignored.
        @(posedge clk); #2;
        valid4 = 1'b1; sel_in4 = 2'd3;
        @(posedge clk); #2;
        sel_in4 = 2'd0;
        repeat (6) @(posedge clk);
        #2 valid4 = 1'b0;
        done_k = 0;
        for (int k = 7; k <= 9; k++) begin
            @(negedge clk);
            if (done4 && done_k == 0) done_k = k;
        end
        cmp("hold done cycle", done_k, 9);
        cmp("hold select", sel4, 3);

        // Current source dies while idle.
        @(posedge clk);
        #2 src4 = 4'b0111;
        if (FB_EN) begin
            @(negedge clk);
            cmp("fb busy", busy4, 1);
            cmp("fb select", sel4, 0);
            done_k = 0;
            for (int k = 2; k <= 9; k++) begin
                @(negedge clk);
                if (err4 && done_k == 0) done_k = k;
            end
            cmp("fb err cycle", done_k, 9);
            cmp("fb err code", code4, 3);
        end else begin
            repeat (4) @(negedge clk);
            cmp("nofb select", sel4, 3);
            cmp("nofb busy", busy4, 0);
        end
        src4 = 4'b1111;

        // Asynchronous reset in the middle of a switch.
        req4(2);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        cmp("async rst select", sel4, 0);
        cmp("async rst busy", busy4, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        cmp("post rst done", done4, 0);
        cmp("post rst err", err4, 0);

        // Randomized traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 699) == 0) begin
                rst = 1'b1;
                @(posedge clk); #2;
                rst = 1'b0;
            end
            valid4  = ($urandom_range(0, 2) == 0);
            sel_in4 = 2'($urandom_range(0, 3));
            valid3  = ($urandom_range(0, 2) == 0);
            sel_in3 = 2'($urandom_range(0, 3));
            for (int b = 0; b < 4; b++) begin
                if (src4[b] ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0))
                    src4[b] = ~src4[b];
                if (b < 3 && (src3[b] ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0)))
                    src3[b] = ~src3[b];
            end
        end
        valid4 = 1'b0;
        valid3 = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
